// File: rtl/dap_sram_arbiter.sv
// Access scheduler for the DAP coefficient/delay SRAM: arbitrates datapath reads against
// loader writes, with write-starvation protection and a full-array clear sweep.
module dap_sram_arbiter #(
  parameter int unsigned       ADDR_W   = 7,
  parameter int unsigned       DATA_W   = 12,
  parameter int unsigned       DEPTH    = 128,
  parameter int unsigned       MAX_WAIT = 4,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {StRun, StClear} state_e;

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              force_wr;
  logic              grant_rd;
  logic              grant_wr;

  // SRAM output latches its word until the next read, so no local capture is needed.
  assign rd_data = sram_o;

  always_comb begin
    force_wr = (wait_q == WAIT_W'(MAX_WAIT));
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    // A clear request on the same edge suppresses any grant.
    if (state_q == StRun && !clr_start) begin
      if (rd_req && !(wr_req && force_wr)) begin
        grant_rd = 1'b1;
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      wait_q   <= '0;
      ptr_q    <= '0;
      rd_gnt   <= 1'b0;
      wr_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      sram_csb <= 1'b1;
      sram_web <= 1'b1;
      sram_oeb <= 1'b1;
      sram_a   <= '0;
      sram_i   <= '0;
    end else begin
      rd_gnt   <= grant_rd;
      wr_gnt   <= grant_wr;
      rd_valid <= rd_gnt;
      clr_done <= 1'b0;
      sram_csb <= 1'b1;
      sram_web <= 1'b1;
      sram_oeb <= 1'b1;

      if (grant_rd) begin
        sram_csb <= 1'b0;
        sram_oeb <= 1'b0;
        sram_a   <= rd_addr;
      end else if (grant_wr) begin
        sram_csb <= 1'b0;
        sram_web <= 1'b0;
        sram_a   <= wr_addr;
        sram_i   <= wr_data;
      end

      if (wr_req && !grant_wr) begin
        if (!force_wr) begin
          wait_q <= wait_q + WAIT_W'(1);
        end
      end else begin
        wait_q <= '0;
      end

      unique case (state_q)
        StRun: begin
          if (clr_start) begin
            state_q <= StClear;
            busy    <= 1'b1;
            ptr_q   <= '0;
          end
        end
        StClear: begin
          sram_csb <= 1'b0;
          sram_web <= 1'b0;
          sram_a   <= ptr_q;
          sram_i   <= CLR_VAL;
          ptr_q    <= ptr_q + ADDR_W'(1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q  <= StRun;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_dap_sram_arbiter.sv
// Directed bench for dap_sram_arbiter with a behavioural 128x12 synchronous SRAM model.
module tb_dap_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req, clr_start;
  logic [6:0]  rd_addr, wr_addr;
  logic [11:0] wr_data;
  logic        rd_gnt, rd_valid, wr_gnt, busy, clr_done;
  logic [11:0] rd_data;
  logic [6:0]  sram_a;
  logic [11:0] sram_i, sram_o;
  logic        sram_csb, sram_web, sram_oeb;

  logic [11:0] mem [128];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dap_sram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done),
    .sram_a    (sram_a),
    .sram_i    (sram_i),
    .sram_o    (sram_o),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb)
  );

  // Synchronous SRAM: output holds its last read word.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o <= mem[sram_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [11:0] data);
    wr_req = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    check("wr_gnt", {31'd0, wr_gnt}, 32'd1);
    wr_req = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [6:0] addr, input logic [11:0] exp);
    rd_req = 1'b1; rd_addr = addr;
    tick();
    check("rd_gnt", {31'd0, rd_gnt}, 32'd1);
    rd_req = 1'b0;
    tick();
    check("rd_valid", {31'd0, rd_valid}, 32'd1);
    check("rd_data", {20'd0, rd_data}, {20'd0, exp});
  endtask

  task automatic run_sweep(input int retrigger_at, output int busy_cnt, output int done_cnt,
                           output int gnt_seen);
    busy_cnt = 0; done_cnt = 0; gnt_seen = 0;
    for (int k = 0; k < 300 && busy; k++) begin
      busy_cnt++;
      if (k == retrigger_at) clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      if (clr_done) done_cnt++;
      if (rd_gnt || wr_gnt) gnt_seen++;
    end
  endtask

  int busy_cnt, done_cnt, gnt_seen;
  logic [11:0] vals [4];

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    vals[0] = 12'h111; vals[1] = 12'h222; vals[2] = 12'h333; vals[3] = 12'h444;
    tick(); tick();
    check("rst_csb", {31'd0, sram_csb}, 32'd1);
    check("rst_web", {31'd0, sram_web}, 32'd1);
    check("rst_oeb", {31'd0, sram_oeb}, 32'd1);
    check("rst_a", {25'd0, sram_a}, 32'd0);
    check("rst_i", {20'd0, sram_i}, 32'd0);
    check("rst_flags", {26'd0, rd_gnt, wr_gnt, rd_valid, busy, clr_done, 1'b0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write then read-back
    wr_req = 1'b1; wr_addr = 7'd5; wr_data = 12'hABC;
    tick();
    check("w1_gnt", {31'd0, wr_gnt}, 32'd1);
    check("w1_strobes", {29'd0, sram_csb, sram_web, sram_oeb}, 32'b001);
    check("w1_a", {25'd0, sram_a}, 32'd5);
    check("w1_i", {20'd0, sram_i}, 32'hABC);
    wr_req = 1'b0;
    tick();
    check("w1_idle", {29'd0, sram_csb, sram_web, sram_oeb}, 32'b111);
    rd_req = 1'b1; rd_addr = 7'd5;
    tick();
    check("r1_gnt", {31'd0, rd_gnt}, 32'd1);
    check("r1_strobes", {29'd0, sram_csb, sram_web, sram_oeb}, 32'b010);
    check("r1_valid_early", {31'd0, rd_valid}, 32'd0);
    rd_req = 1'b0;
    tick();
    check("r1_valid", {31'd0, rd_valid}, 32'd1);
    check("r1_data", {20'd0, rd_data}, 32'hABC);
    tick();
    check("r1_valid_pulse", {31'd0, rd_valid}, 32'd0);

    // Back-to-back reads
    for (int k = 0; k < 4; k++) do_write(7'(k), vals[k]);
    rd_req = 1'b1; rd_addr = 7'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b2b_gnt", {31'd0, rd_gnt}, 32'd1);
      if (k >= 1) begin
        check("b2b_valid", {31'd0, rd_valid}, 32'd1);
        check("b2b_data", {20'd0, rd_data}, {20'd0, vals[k-1]});
      end
      if (k < 3) rd_addr = 7'(k + 1);
      else rd_req = 1'b0;
    end
    tick();
    check("b2b_valid_last", {31'd0, rd_valid}, 32'd1);
    check("b2b_data_last", {20'd0, rd_data}, 32'h444);
    check("b2b_gnt_end", {31'd0, rd_gnt}, 32'd0);
    tick();

    // Write starvation: 4 reads then a forced write, repeating
    rd_req = 1'b1; rd_addr = 7'd0; wr_req = 1'b1; wr_addr = 7'd10; wr_data = 12'h5A5;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("starve_rd", {31'd0, rd_gnt}, {31'd0, (k % 5) != 4});
      check("starve_wr", {31'd0, wr_gnt}, {31'd0, (k % 5) == 4});
    end
    rd_req = 1'b0; wr_req = 1'b0;
    tick(); tick();

    // Clear sweep
    do_write(7'd0, 12'hFFF);
    do_write(7'd127, 12'hFFF);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("clr_busy_start", {31'd0, busy}, 32'd1);
    rd_req = 1'b1; rd_addr = 7'd0;
    run_sweep(-1, busy_cnt, done_cnt, gnt_seen);
    check("clr_busy_cycles", busy_cnt, 128);
    check("clr_no_gnt", gnt_seen, 0);
    tick();
    if (clr_done) done_cnt++;
    check("clr_done_count", done_cnt, 1);
    check("clr_rd_after", {31'd0, rd_gnt}, 32'd1);
    rd_req = 1'b0;
    tick();
    check("clr_rd0_valid", {31'd0, rd_valid}, 32'd1);
    check("clr_rd0_data", {20'd0, rd_data}, 32'h000);
    do_read(7'd127, 12'h000);

    // Clear contention and ignored retrigger
    wr_req = 1'b1; wr_addr = 7'd3; wr_data = 12'h777; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("cc_no_gnt", {31'd0, wr_gnt}, 32'd0);
    check("cc_busy", {31'd0, busy}, 32'd1);
    run_sweep(50, busy_cnt, done_cnt, gnt_seen);
    check("cc_busy_cycles", busy_cnt, 128);
    check("cc_no_gnt_sweep", gnt_seen, 0);
    check("cc_done", done_cnt, 1);
    tick();
    check("cc_wr_gnt", {31'd0, wr_gnt}, 32'd1);
    check("cc_busy_low", {31'd0, busy}, 32'd0);
    wr_req = 1'b0;
    tick();
    do_read(7'd3, 12'h777);

    // Reset mid-sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 60; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_strobes", {29'd0, sram_csb, sram_web, sram_oeb}, 32'b111);
    check("mr_a", {25'd0, sram_a}, 32'd0);
    check("mr_i", {20'd0, sram_i}, 32'd0);
    check("mr_flags", {28'd0, rd_gnt, wr_gnt, rd_valid, clr_done}, 32'd0);
    tick();
    #2 rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (clr_done || busy) done_cnt++;
    end
    check("mr_no_done", done_cnt, 0);
    do_write(7'd9, 12'h123);
    do_read(7'd9, 12'h123);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
